// File: rtl/mem_access.sv
// Memory-access stage: issues one data-SRAM request per load/store, aligns
// and extends load data, builds store strobes and hands a writeback bundle on.
module mem_access #(
    parameter bit ALE_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_result,
    input  logic        in_wreg_en,
    input  logic [4:0]  in_wreg_idx,
    input  logic [4:0]  in_mop,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_result,
    output logic        out_wreg_en,
    output logic [4:0]  out_wreg_idx,
    output logic        out_ale,
    output logic        byp_en,
    output logic        byp_pending
);
    typedef enum logic [1:0] {S_EMPTY, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      r_state;
    logic        r_drop;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_result;
    logic        r_wreg_en;
    logic [4:0]  r_wreg_idx;
    logic        r_ale;
    logic        r_ld;
    logic        r_st;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [3:0]  r_wstrb;

    logic        w_in_ld;
    logic        w_in_st;
    logic        w_in_uns;
    logic [1:0]  w_in_size;
    logic        w_in_ale;
    logic        w_accept;
    logic [3:0]  w_in_wstrb;
    logic [31:0] w_in_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    assign w_in_ld   = in_mop[0];
    assign w_in_st   = in_mop[1];
    assign w_in_size = in_mop[3:2];
    assign w_in_uns  = in_mop[4];

    assign w_in_ale = ALE_CHECK & (w_in_ld | w_in_st) &
                      (((w_in_size == 2'd1) & in_addr[0]) |
                       ((w_in_size == 2'd2) & (in_addr[1:0] != 2'b00)));

    assign in_ready = ~r_drop & ((r_state == S_EMPTY) | ((r_state == S_DONE) & out_ready));
    assign w_accept = in_valid & in_ready & ~flush;

    // Store strobe and lane-replicated write data for the incoming instruction
    always_comb begin
        w_in_wstrb = 4'b0000;
        w_in_wdata = in_wdata;
        if (w_in_st) begin
            case (w_in_size)
                2'd0: begin
                    w_in_wstrb = 4'b0001 << in_addr[1:0];
                    w_in_wdata = {4{in_wdata[7:0]}};
                end
                2'd1: begin
                    w_in_wstrb = 4'b0011 << {in_addr[1], 1'b0};
                    w_in_wdata = {2{in_wdata[15:0]}};
                end
                default: w_in_wstrb = 4'b1111;
            endcase
        end
    end

    // Load data alignment and sign/zero extension
    always_comb begin
        w_byte     = 8'(data_rdata >> {r_addr[1:0], 3'b000});
        w_half     = 16'(data_rdata >> {r_addr[1], 4'b0000});
        w_load_val = data_rdata;
        case (r_size)
            2'd0:    w_load_val = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            2'd1:    w_load_val = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            default: w_load_val = data_rdata;
        endcase
    end

    // Stage FSM, captured instruction fields and late-response drop tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_EMPTY;
            r_drop     <= 1'b0;
            r_pc       <= 32'h0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_result   <= 32'h0;
            r_wreg_en  <= 1'b0;
            r_wreg_idx <= 5'h0;
            r_ale      <= 1'b0;
            r_ld       <= 1'b0;
            r_st       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'd0;
            r_wstrb    <= 4'b0000;
        end else begin
            if (r_drop && data_data_ok) begin
                r_drop <= 1'b0;
            end
            if (flush) begin
                r_state <= S_EMPTY;
                // a request already accepted by the SRAM still owes a data_ok
                if (((r_state == S_REQ) && data_addr_ok) ||
                    ((r_state == S_WAIT) && !data_data_ok)) begin
                    r_drop <= 1'b1;
                end
            end else if (w_accept) begin
                r_pc       <= in_pc;
                r_addr     <= in_addr;
                r_wdata    <= w_in_wdata;
                r_result   <= w_in_ale ? in_addr : in_result;
                r_wreg_en  <= in_wreg_en & ~w_in_ale;
                r_wreg_idx <= in_wreg_idx;
                r_ale      <= w_in_ale;
                r_ld       <= w_in_ld;
                r_st       <= w_in_st;
                r_uns      <= w_in_uns;
                r_size     <= w_in_size;
                r_wstrb    <= w_in_wstrb;
                r_state    <= ((w_in_ld | w_in_st) & ~w_in_ale) ? S_REQ : S_DONE;
            end else begin
                case (r_state)
                    S_REQ:  if (data_addr_ok) r_state <= S_WAIT;
                    S_WAIT: if (data_data_ok) begin
                        r_state <= S_DONE;
                        if (r_ld) r_result <= w_load_val;
                    end
                    S_DONE: if (out_ready) r_state <= S_EMPTY;
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign data_req     = (r_state == S_REQ);
    assign data_wr      = r_st;
    assign data_size    = r_size;
    assign data_addr    = r_addr;
    assign data_wstrb   = r_wstrb;
    assign data_wdata   = r_wdata;
    assign out_valid    = (r_state == S_DONE);
    assign out_pc       = r_pc;
    assign out_result   = r_result;
    assign out_wreg_en  = r_wreg_en;
    assign out_wreg_idx = r_wreg_idx;
    assign out_ale      = r_ale;
    assign byp_en       = (r_state != S_EMPTY) & r_wreg_en;
    assign byp_pending  = ((r_state == S_REQ) | (r_state == S_WAIT)) & r_ld;

endmodule
